ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Sits directly downstream of the PS/2 scan-code receiver.
- Consumes its 16-bit code, make/break flag and one-cycle done strobe.
- Tracks modifier state (shift, ctrl, caps lock) and translates set-2 make codes into 8-bit ASCII.
- Buffers the characters in a small FIFO, read by the application, such as a UART bridge or an on-screen console, over a valid/ready handshake.

Parameters:
FIFO_DEPTH, 8, character FIFO entries; must be a power of two, minimum 2
ADDR_W, 3, log2(FIFO_DEPTH)

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset; one clock, reset is asynchronous and active-low
key_code_i  input  16  scan code: [15:8] = 8'h00 (single-byte) or 8'hE0 (extended); [7:0] = code
key_break_i  input  2  2'b10 = make, 2'b01 = break; other values are invalid
key_done_i  input  1  one-cycle strobe; key_code_i and key_break_i are valid only in this cycle
ascii_o  output  8  character at the FIFO head
ascii_valid_o  output  1  FIFO non-empty
ascii_ready_i  input  1  consumer accepts; pop occurs when ascii_valid_o and ascii_ready_i are both high
fifo_count_o  output  ADDR_W+1  occupancy, 0..FIFO_DEPTH
overflow_o  output  1  sticky; set when a character is dropped on a full FIFO
shift_o  output  1  either shift key held
ctrl_o  output  1  either ctrl key held
caps_o  output  1  caps-lock toggle state

Behaviour:
- Reset values: all outputs 0, FIFO empty, pointers 0, all modifier and held flags 0.
- Events are sampled only when key_done_i = 1. Events with key_break_i = 00 or 11 are ignored entirely.
- Modifier keys: L-shift 00_12, R-shift 00_59, L-ctrl 00_14, R-ctrl E0_14.
  - Make sets the per-key held flag; break clears it.
  - shift_o = lshift | rshift; ctrl_o = lctrl | rctrl.
  - Modifier keys never produce a character.
- Caps lock (00_58):
  - Make toggles caps_o only while caps_held = 0, then sets caps_held. Typematic repeats therefore do not re-toggle.
  - Break clears caps_held.
- Translation applies to make events only; breaks of non-modifier keys are ignored.
  - Letters a..z (1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A): lowercase ASCII; uppercase when shift_o XOR caps_o.
  - Digits 1..9,0 (16,1E,26,25,2E,36,3D,3E,46,45): ASCII '1'..'0'. With shift_o they map to ! @ # $ % ^ & * ( ). caps_o has no effect on digits.
  - 00_29 -> 0x20; 00_5A and E0_5A -> 0x0D; 00_66 -> 0x08; 00_76 -> 0x1B.
  - When ctrl_o = 1 and the key is a letter, output = uppercase code & 8'h1F (ctrl-a = 0x01), regardless of shift and caps.
  - Any other code, including every other E0 code, produces no character.
- Modifier state used for translation is the value before the current event takes effect.
- Latency: strobe in cycle N; decode registered in N+1 and pushed at the end of N+1. ascii_valid_o and ascii_o update in N+2. Typematic makes each push a character.
- FIFO:
  - Show-ahead: ascii_o reflects the head whenever ascii_valid_o = 1. ascii_o holds its last value when empty.
  - Pointers wrap modulo FIFO_DEPTH; count distinguishes full from empty.
  - Push when full without a same-cycle pop: character dropped, overflow_o <= 1, FIFO contents unchanged.
  - Push and pop in the same cycle (including when full or when count = 1): both succeed, count unchanged.
  - Pop with ready while empty: no effect.
- Reset asserted mid-operation clears the FIFO, overflow_o, all modifiers and caps_o immediately (asynchronous). The decode stage discards any in-flight event.

Test Plan:
- After reset, strobe make 00_1C -> ascii_valid_o = 1 two cycles later with ascii_o = 0x61, fifo_count_o = 1. Pulse ascii_ready_i -> valid drops, count 0.
- Make 00_12, make 00_1C, break 00_12, make 00_1C -> FIFO holds 0x41 then 0x61. Make 00_16 with shift held -> 0x21.
- Make 00_58 three times without a break, then break, then make 00_32 -> caps_o = 1, output 0x42. Repeat with shift held -> 0x62.
- Make E0_14 then 00_21 -> 0x03. Make E0_5A -> 0x0D. Make E0_75 -> nothing pushed.
- Push FIFO_DEPTH+1 characters with ready low -> count 8, overflow_o = 1, first 8 characters read out in order. Then assert simultaneous push and pop at full -> count stays 8.
- Assert rst_i low while FIFO holds 3 characters and caps_o = 1 -> all outputs 0 immediately. A following make 00_1C yields 0x61.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 key decoder: tracks shift/ctrl/caps and queues ASCII characters in a show-ahead FIFO.
// Latency: strobe cycle N -> char registered N+1, visible N+2; full FIFO drops new characters (sticky overflow).

module ps2_key_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int DAT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_vld,
  input  logic [DAT_W-1:0]  push_dat,
  input  logic              pop_rdy,
  output logic              pop_vld,
  output logic [DAT_W-1:0]  head_dat,
  output logic [ADDR_W:0]   count,
  output logic              full
);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DAT_W-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign pop_vld  = (count != '0);
  assign full     = (count == FULL_CNT);
  assign head_dat = mem[rd_ptr];
  assign do_pop   = pop_vld & pop_rdy;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign do_push  = push_vld & (~full | do_pop);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module ps2_key_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [15:0]       key_code_i,
  input  logic [1:0]        key_break_i,
  input  logic              key_done_i,
  output logic [7:0]        ascii_o,
  output logic              ascii_valid_o,
  input  logic              ascii_ready_i,
  output logic [ADDR_W:0]   fifo_count_o,
  output logic              overflow_o,
  output logic              shift_o,
  output logic              ctrl_o,
  output logic              caps_o
);
  logic       lshift, rshift, lctrl, rctrl, caps_held, caps_q;
  logic       char_vld;
  logic [7:0] char_dat;
  logic [7:0] last_dat;
  logic [7:0] head_dat;
  logic       fifo_full;
  logic       is_make, is_break, std_pfx, ext_pfx;
  logic [7:0] code;
  logic       is_letter, is_digit;
  logic [4:0] lidx;
  logic [7:0] dig_plain, dig_shift;
  logic       xl_vld;
  logic [7:0] xl_dat;

  assign code     = key_code_i[7:0];
  assign std_pfx  = (key_code_i[15:8] == 8'h00);
  assign ext_pfx  = (key_code_i[15:8] == 8'hE0);
  assign is_make  = key_done_i & (key_break_i == 2'b10);
  assign is_break = key_done_i & (key_break_i == 2'b01);

  assign shift_o = lshift | rshift;
  assign ctrl_o  = lctrl | rctrl;
  assign caps_o  = caps_q;

  always_comb begin
    is_letter = 1'b1;
    lidx      = 5'd0;
    case (code)
      8'h1C: lidx = 5'd0;   8'h32: lidx = 5'd1;   8'h21: lidx = 5'd2;   8'h23: lidx = 5'd3;
      8'h24: lidx = 5'd4;   8'h2B: lidx = 5'd5;   8'h34: lidx = 5'd6;   8'h33: lidx = 5'd7;
      8'h43: lidx = 5'd8;   8'h3B: lidx = 5'd9;   8'h42: lidx = 5'd10;  8'h4B: lidx = 5'd11;
      8'h3A: lidx = 5'd12;  8'h31: lidx = 5'd13;  8'h44: lidx = 5'd14;  8'h4D: lidx = 5'd15;
      8'h15: lidx = 5'd16;  8'h2D: lidx = 5'd17;  8'h1B: lidx = 5'd18;  8'h2C: lidx = 5'd19;
      8'h3C: lidx = 5'd20;  8'h2A: lidx = 5'd21;  8'h1D: lidx = 5'd22;  8'h22: lidx = 5'd23;
      8'h35: lidx = 5'd24;  8'h1A: lidx = 5'd25;
      default: is_letter = 1'b0;
    endcase
  end

  always_comb begin
    is_digit  = 1'b1;
    dig_plain = 8'h00;
    dig_shift = 8'h00;
    case (code)
      8'h16: begin dig_plain = 8'h31; dig_shift = 8'h21; end
      8'h1E: begin dig_plain = 8'h32; dig_shift = 8'h40; end
      8'h26: begin dig_plain = 8'h33; dig_shift = 8'h23; end
      8'h25: begin dig_plain = 8'h34; dig_shift = 8'h24; end
      8'h2E: begin dig_plain = 8'h35; dig_shift = 8'h25; end
      8'h36: begin dig_plain = 8'h36; dig_shift = 8'h5E; end
      8'h3D: begin dig_plain = 8'h37; dig_shift = 8'h26; end
      8'h3E: begin dig_plain = 8'h38; dig_shift = 8'h2A; end
      8'h46: begin dig_plain = 8'h39; dig_shift = 8'h28; end
      8'h45: begin dig_plain = 8'h30; dig_shift = 8'h29; end
      default: is_digit = 1'b0;
    endcase
  end

  // Translation sees modifier state from before this event is applied.
  always_comb begin
    xl_vld = 1'b0;
    xl_dat = 8'h00;
    if (std_pfx) begin
      if (is_letter) begin
        xl_vld = 1'b1;
        if (ctrl_o)                xl_dat = {3'b000, lidx + 5'd1};
        else if (shift_o ^ caps_q) xl_dat = 8'h41 + {3'b000, lidx};
        else                       xl_dat = 8'h61 + {3'b000, lidx};
      end else if (is_digit) begin
        xl_vld = 1'b1;
        xl_dat = shift_o ? dig_shift : dig_plain;
      end else begin
        case (code)
          8'h29:   begin xl_vld = 1'b1; xl_dat = 8'h20; end
          8'h5A:   begin xl_vld = 1'b1; xl_dat = 8'h0D; end
          8'h66:   begin xl_vld = 1'b1; xl_dat = 8'h08; end
          8'h76:   begin xl_vld = 1'b1; xl_dat = 8'h1B; end
          default: xl_vld = 1'b0;
        endcase
      end
    end else if (ext_pfx && code == 8'h5A) begin
      xl_vld = 1'b1;
      xl_dat = 8'h0D;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      lctrl     <= 1'b0;
      rctrl     <= 1'b0;
      caps_held <= 1'b0;
      caps_q    <= 1'b0;
      char_vld  <= 1'b0;
      char_dat  <= 8'h00;
    end else begin
      char_vld <= is_make & xl_vld;
      if (is_make & xl_vld) char_dat <= xl_dat;
      if (is_make | is_break) begin
        if (std_pfx && code == 8'h12) lshift <= is_make;
        if (std_pfx && code == 8'h59) rshift <= is_make;
        if (std_pfx && code == 8'h14) lctrl  <= is_make;
        if (ext_pfx && code == 8'h14) rctrl  <= is_make;
        // Only the first make of a held caps key toggles; typematic repeats do not.
        if (std_pfx && code == 8'h58) begin
          if (is_make && !caps_held) caps_q <= ~caps_q;
          caps_held <= is_make;
        end
      end
    end
  end

  ps2_key_fifo #(.DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W), .DAT_W(8)) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_vld (char_vld),
    .push_dat (char_dat),
    .pop_rdy  (ascii_ready_i),
    .pop_vld  (ascii_valid_o),
    .head_dat (head_dat),
    .count    (fifo_count_o),
    .full     (fifo_full)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      overflow_o <= 1'b0;
      last_dat   <= 8'h00;
    end else begin
      if (char_vld && fifo_full && !(ascii_valid_o && ascii_ready_i)) overflow_o <= 1'b1;
      if (ascii_valid_o && ascii_ready_i) last_dat <= head_dat;
    end
  end

  // Once drained, keep showing the most recently consumed character.
  assign ascii_o = ascii_valid_o ? head_dat : last_dat;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomized scoreboard bench for ps2_key_decoder with a keyboard-level reference model.
module tb_ps2_key_decoder;
  localparam int FIFO_DEPTH = 8;
  localparam int ADDR_W     = 3;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic [15:0]       key_code_i = '0;
  logic [1:0]        key_break_i = '0;
  logic              key_done_i = 1'b0;
  logic [7:0]        ascii_o;
  logic              ascii_valid_o;
  logic              ascii_ready_i = 1'b0;
  logic [ADDR_W:0]   fifo_count_o;
  logic              overflow_o;
  logic              shift_o;
  logic              ctrl_o;
  logic              caps_o;

  ps2_key_decoder #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .key_code_i(key_code_i), .key_break_i(key_break_i),
    .key_done_i(key_done_i), .ascii_o(ascii_o), .ascii_valid_o(ascii_valid_o),
    .ascii_ready_i(ascii_ready_i), .fifo_count_o(fifo_count_o), .overflow_o(overflow_o),
    .shift_o(shift_o), .ctrl_o(ctrl_o), .caps_o(caps_o)
  );

  initial forever #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  bit rand_en = 0;
  bit ready_cmd = 0;
  bit pop_same = 0;

  // Reference keyboard state
  bit m_lsh, m_rsh, m_lct, m_rct, m_caps, m_caps_held;
  string letters = "abcdefghijklmnopqrstuvwxyz";
  string dig_pl  = "1234567890";
  string dig_sh  = "!@#$%^&*()";
  logic [7:0] lcodes [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,8'h42,8'h4B,8'h3A,
                              8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  logic [7:0] dcodes [10] = '{8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,8'h45};
  logic [15:0] pool [20] = '{16'h001C,16'h0032,16'h0021,16'h004D,16'h001A,16'h0016,16'h0045,16'h0036,
                             16'h0012,16'h0059,16'h0014,16'hE014,16'h0058,16'h0029,16'h005A,16'hE05A,
                             16'h0066,16'h0076,16'hE075,16'hE01C};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_lsh = 0; m_rsh = 0; m_lct = 0; m_rct = 0; m_caps = 0; m_caps_held = 0;
    exp_q.delete();
  endtask

  task automatic model_ev(input logic [15:0] code, input logic [1:0] brk, output int ch);
    bit mk, sh, ct;
    ch = -1;
    if (brk != 2'b10 && brk != 2'b01) return;
    mk = (brk == 2'b10);
    sh = m_lsh | m_rsh;
    ct = m_lct | m_rct;
    if (mk && code[15:8] == 8'h00) begin
      for (int i = 0; i < 26; i++)
        if (lcodes[i] == code[7:0]) begin
          if (ct)              ch = (int'(letters[i]) - 32) & 'h1F;
          else if (sh ^ m_caps) ch = int'(letters[i]) - 32;
          else                 ch = int'(letters[i]);
        end
      for (int i = 0; i < 10; i++)
        if (dcodes[i] == code[7:0]) ch = sh ? int'(dig_sh[i]) : int'(dig_pl[i]);
      case (code[7:0])
        8'h29: ch = 32;
        8'h5A: ch = 13;
        8'h66: ch = 8;
        8'h76: ch = 27;
        default: ;
      endcase
    end else if (mk && code == 16'hE05A) ch = 13;
    case (code)
      16'h0012: m_lsh = mk;
      16'h0059: m_rsh = mk;
      16'h0014: m_lct = mk;
      16'hE014: m_rct = mk;
      16'h0058: begin
        if (mk && !m_caps_held) m_caps = ~m_caps;
        m_caps_held = mk;
      end
      default: ;
    endcase
  endtask

  task automatic sb_push(input logic [7:0] v);
    if (exp_q.size() >= FIFO_DEPTH && !pop_same) ; // dropped on a full FIFO
    else exp_q.push_back(v);
  endtask

  // exp: >=0 fixed expected char, -1 none, -2 take the reference model's answer
  task automatic send(input logic [15:0] code, input logic [1:0] brk, input int exp);
    int mch, use_ch;
    @(posedge clk_i); #1;
    key_code_i = code; key_break_i = brk; key_done_i = 1'b1;
    model_ev(code, brk, mch);
    use_ch = (exp == -2) ? mch : exp;
    if (use_ch >= 0) sb_push(use_ch[7:0]);
    @(posedge clk_i); #1;
    key_done_i = 1'b0; key_code_i = '0; key_break_i = '0;
    chk("shift_o", 32'(shift_o), 32'(m_lsh | m_rsh));
    chk("ctrl_o",  32'(ctrl_o),  32'(m_lct | m_rct));
    chk("caps_o",  32'(caps_o),  32'(m_caps));
  endtask

  task automatic drain();
    int guard = 0;
    ready_cmd = 1;
    while ((exp_q.size() != 0 || ascii_valid_o) && guard < 200) begin
      @(posedge clk_i); #1; guard++;
    end
    if (guard >= 200) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d chars still expected, valid=%0d", exp_q.size(), ascii_valid_o);
      exp_q.delete();
    end
    ready_cmd = 0;
    @(posedge clk_i); #1;
    chk("drain_valid", 32'(ascii_valid_o), 32'd0);
    chk("drain_count", 32'(fifo_count_o), 32'd0);
  endtask

  // Single driver of ascii_ready_i, updated shortly after each rising edge
  initial forever begin
    @(posedge clk_i); #2;
    ascii_ready_i = rand_en ? 1'($urandom_range(0, 1)) : ready_cmd;
  end

  // Monitor: every accepted character must match the scoreboard head
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk_i);
      if (rst_i && ascii_valid_o && ascii_ready_i) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL pop_unexpected: got 0x%0h, expected no character", ascii_o);
        end else begin
          e = exp_q.pop_front();
          chk("pop_char", 32'(ascii_o), 32'(e));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    logic [15:0] c;
    logic [1:0]  b;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_valid", 32'(ascii_valid_o), 32'd0);
    chk("rst_count", 32'(fifo_count_o), 32'd0);
    chk("rst_ovf",   32'(overflow_o), 32'd0);
    chk("rst_ascii", 32'(ascii_o), 32'd0);
    chk("rst_mods",  32'({shift_o, ctrl_o, caps_o}), 32'd0);
    rst_i = 1'b1;

    // Latency and single pop
    send(16'h001C, 2'b10, 8'h61);
    chk("lat_n1_valid", 32'(ascii_valid_o), 32'd0);
    @(posedge clk_i); #1;
    chk("lat_n2_valid", 32'(ascii_valid_o), 32'd1);
    chk("lat_n2_ascii", 32'(ascii_o), 32'h61);
    chk("lat_n2_count", 32'(fifo_count_o), 32'd1);
    ready_cmd = 1;
    @(posedge clk_i); #1;
    ready_cmd = 0;
    chk("pop_valid", 32'(ascii_valid_o), 32'd0);
    chk("pop_count", 32'(fifo_count_o), 32'd0);
    chk("hold_ascii", 32'(ascii_o), 32'h61);

    // Shift
    ready_cmd = 1;
    send(16'h0012, 2'b10, -1);
    send(16'h001C, 2'b10, 8'h41);
    send(16'h0012, 2'b01, -1);
    send(16'h001C, 2'b10, 8'h61);
    send(16'h0059, 2'b10, -1);
    send(16'h0016, 2'b10, 8'h21);
    send(16'h0059, 2'b01, -1);
    send(16'h001C, 2'b01, -1);
    send(16'h001C, 2'b00, -1);
    send(16'h0012, 2'b11, -1);
    chk("inv_shift", 32'(shift_o), 32'd0);
    drain();

    // Caps lock with typematic repeat
    ready_cmd = 1;
    repeat (3) send(16'h0058, 2'b10, -1);
    send(16'h0058, 2'b01, -1);
    chk("caps_set", 32'(caps_o), 32'd1);
    send(16'h0032, 2'b10, 8'h42);
    send(16'h0012, 2'b10, -1);
    send(16'h0032, 2'b10, 8'h62);
    send(16'h0026, 2'b10, 8'h23);
    send(16'h0012, 2'b01, -1);
    send(16'h0026, 2'b10, 8'h33);

    // Ctrl and extended codes
    send(16'hE014, 2'b10, -1);
    send(16'h0021, 2'b10, 8'h03);
    send(16'hE014, 2'b01, -1);
    send(16'hE05A, 2'b10, 8'h0D);
    send(16'hE075, 2'b10, -1);
    send(16'h0029, 2'b10, 8'h20);
    send(16'h0066, 2'b10, 8'h08);
    send(16'h0076, 2'b10, 8'h1B);
    send(16'h0058, 2'b10, -1);
    send(16'h0058, 2'b01, -1);
    drain();

    // Overflow then simultaneous push/pop at full
    ready_cmd = 0;
    for (int i = 0; i < FIFO_DEPTH + 1; i++) send({8'h00, lcodes[i]}, 2'b10, 8'h61 + i);
    @(posedge clk_i); #1;
    chk("full_count", 32'(fifo_count_o), 32'(FIFO_DEPTH));
    chk("ovf_set",    32'(overflow_o), 32'd1);
    chk("full_head",  32'(ascii_o), 32'h61);
    pop_same = 1;
    send(16'h003B, 2'b10, 8'h6A);
    ready_cmd = 1;
    @(posedge clk_i); #1;
    ready_cmd = 0;
    pop_same = 0;
    chk("pushpop_count", 32'(fifo_count_o), 32'(FIFO_DEPTH));
    chk("pushpop_head",  32'(ascii_o), 32'h62);
    drain();
    chk("ovf_sticky", 32'(overflow_o), 32'd1);

    // Asynchronous reset mid-operation
    send(16'h0058, 2'b10, -1);
    send(16'h0058, 2'b01, -1);
    send(16'h0012, 2'b10, -1);
    send(16'h0024, 2'b10, -2);
    send(16'h0016, 2'b10, -2);
    send(16'h0045, 2'b10, -2);
    @(posedge clk_i); #1;
    chk("pre_rst_count", 32'(fifo_count_o), 32'd3);
    chk("pre_rst_caps",  32'(caps_o), 32'd1);
    send(16'h001A, 2'b10, -1);
    #2 rst_i = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(ascii_valid_o), 32'd0);
    chk("mid_rst_count", 32'(fifo_count_o), 32'd0);
    chk("mid_rst_ovf",   32'(overflow_o), 32'd0);
    chk("mid_rst_ascii", 32'(ascii_o), 32'd0);
    chk("mid_rst_mods",  32'({shift_o, ctrl_o, caps_o}), 32'd0);
    model_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    chk("post_rst_valid", 32'(ascii_valid_o), 32'd0);
    send(16'h001C, 2'b10, 8'h61);
    drain();

    // Randomized traffic against the reference model
    rand_en = 1;
    for (int n = 0; n < 500; n++) begin
      guard = 0;
      while (exp_q.size() >= FIFO_DEPTH - 1 && guard < 100) begin
        @(posedge clk_i); #1; guard++;
      end
      if (guard >= 100) begin
        tests++; fails++;
        $display("FAIL rand_stall: queue stuck at %0d entries", exp_q.size());
      end
      if ($urandom_range(0, 7) == 0) c = {8'h00, 8'($urandom_range(0, 255))};
      else c = pool[$urandom_range(0, 19)];
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: b = 2'b10;
        6, 7, 8:          b = 2'b01;
        default:          b = $urandom_range(0, 1) ? 2'b00 : 2'b11;
      endcase
      send(c, b, -2);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk_i);
    end
    rand_en = 0;
    drain();
    chk("final_ovf", 32'(overflow_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
